// File: rtl/gpio_cmd_pkg.sv
// Shared definitions for the GPIO command controller: command codes, command-word
// field positions, FSM state encoding and the memory-read wait length.
package gpio_cmd_pkg;

    localparam int CMD_MSB = 31;
    localparam int CMD_LSB = 24;
    localparam int ENB_BIT = 23;
    localparam int ARG_MSB = 22;
    localparam int ARG_LSB = 0;
    localparam int CMD_W   = CMD_MSB - CMD_LSB + 1;
    localparam int ARG_W   = ARG_MSB - ARG_LSB + 1;

    localparam logic [CMD_W-1:0] CMD_RESET    = 8'd0;
    localparam logic [CMD_W-1:0] CMD_ENB_TX   = 8'd1;
    localparam logic [CMD_W-1:0] CMD_ENB_RX   = 8'd2;
    localparam logic [CMD_W-1:0] CMD_PHASE    = 8'd3;
    localparam logic [CMD_W-1:0] CMD_RUN_MEM  = 8'd4;
    localparam logic [CMD_W-1:0] CMD_READ_MEM = 8'd5;
    localparam logic [CMD_W-1:0] CMD_ADDR_MEM = 8'd6;
    localparam logic [CMD_W-1:0] CMD_BER_S_I  = 8'd7;
    localparam logic [CMD_W-1:0] CMD_BER_S_Q  = 8'd8;
    localparam logic [CMD_W-1:0] CMD_BER_E_I  = 8'd9;
    localparam logic [CMD_W-1:0] CMD_BER_E_Q  = 8'd10;
    localparam logic [CMD_W-1:0] CMD_BER_H    = 8'd11;
    localparam logic [CMD_W-1:0] CMD_MEM_FULL = 8'd12;

    // Clocks spent waiting for the log memory read data after the address is set.
    localparam int MEM_WAIT_CYC = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
        ST_MEM_WAIT,
        ST_RST_HOLD,
        ST_WAIT_REL
    } state_e;

endpackage

// File: rtl/gpio_cmd_gpo_sync.sv
// Parameterized-width two-flop synchronizer for the processor command word.
module gpo_sync #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/gpio_cmd_ctrl.sv
// Processor GPIO command decoder: edge-triggered command FSM driving control outputs and read-back.
// Optional macro GPIO_CMD_BER_SNAPSHOT_EN: command 7 freezes all four BER counters for coherent reads.
module gpio_cmd_ctrl
    import gpio_cmd_pkg::*;
#(
    parameter int BRAM_ADDR_WIDTH = 15,
    parameter int BRAM_DATA_WIDTH = 16,
    parameter int NB_BER          = 64,
    parameter int RST_PULSE_CYC   = 16
) (
    input  logic                       clk,
    input  logic                       i_resetn,
    input  logic [31:0]                i_gpo,
    output logic [31:0]                o_gpi,
    output logic                       o_rst,
    output logic                       o_enb_tx,
    output logic                       o_enb_rx,
    output logic [1:0]                 o_phase_sel,
    output logic                       o_run_log,
    output logic                       o_read_log,
    output logic [BRAM_ADDR_WIDTH-1:0] o_addr_log,
    input  logic [BRAM_DATA_WIDTH-1:0] i_log_data,
    input  logic                       i_mem_full,
    input  logic [NB_BER-1:0]          i_ber_samp_i,
    input  logic [NB_BER-1:0]          i_ber_samp_q,
    input  logic [NB_BER-1:0]          i_ber_err_i,
    input  logic [NB_BER-1:0]          i_ber_err_q
);

    localparam int                CNT_W    = $clog2(RST_PULSE_CYC + MEM_WAIT_CYC);
    localparam logic [CNT_W-1:0]  RST_LAST = CNT_W'(RST_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0]  MEM_LAST = CNT_W'(MEM_WAIT_CYC - 1);

    logic [31:0]      gpoSync;
    logic [CMD_W-1:0] cmdCode;
    logic [ARG_W-1:0] argField;
    logic             enbSync;
    logic             cmdEdge;
    logic             unusedArgBits;

    gpo_sync #(.WIDTH(32)) uGpoSync (
        .clk   (clk),
        .rst_n (i_resetn),
        .d_i   (i_gpo),
        .q_o   (gpoSync)
    );

    assign cmdCode       = gpoSync[CMD_MSB:CMD_LSB];
    assign enbSync       = gpoSync[ENB_BIT];
    assign argField      = gpoSync[ARG_MSB:ARG_LSB];
    assign unusedArgBits = ^argField;

    state_e                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [1:0]                 settle_q, settle_d;
    logic                       armed_q, armed_d;
    logic                       enbPrev_q, enbPrev_d;
    logic [31:0]                gpi_q, gpi_d;
    logic [31:0]                shadow_q, shadow_d;
    logic                       rst_q, rst_d;
    logic                       enbTx_q, enbTx_d;
    logic                       enbRx_q, enbRx_d;
    logic [1:0]                 phaseSel_q, phaseSel_d;
    logic                       runLog_q, runLog_d;
    logic                       readLog_q, readLog_d;
    logic [BRAM_ADDR_WIDTH-1:0] addrLog_q, addrLog_d;
    logic [NB_BER-1:0]          berSel;

`ifdef GPIO_CMD_BER_SNAPSHOT_EN
    logic [NB_BER-1:0] snapSI_q, snapSI_d;
    logic [NB_BER-1:0] snapSQ_q, snapSQ_d;
    logic [NB_BER-1:0] snapEI_q, snapEI_d;
    logic [NB_BER-1:0] snapEQ_q, snapEQ_d;
`endif

    // The synchronizer output is only trusted once both stages hold post-reset samples;
    // a level already high at that point must be seen low before any rise counts.
    assign cmdEdge = armed_q & enbSync & ~enbPrev_q;

    always_comb begin
`ifdef GPIO_CMD_BER_SNAPSHOT_EN
        case (cmdCode)
            CMD_BER_S_Q: berSel = snapSQ_q;
            CMD_BER_E_I: berSel = snapEI_q;
            CMD_BER_E_Q: berSel = snapEQ_q;
            default:     berSel = i_ber_samp_i;
        endcase
`else
        case (cmdCode)
            CMD_BER_S_Q: berSel = i_ber_samp_q;
            CMD_BER_E_I: berSel = i_ber_err_i;
            CMD_BER_E_Q: berSel = i_ber_err_q;
            default:     berSel = i_ber_samp_i;
        endcase
`endif
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        settle_d   = {settle_q[0], 1'b1};
        armed_d    = armed_q | (settle_q[1] & ~enbSync);
        enbPrev_d  = enbSync;
        gpi_d      = gpi_q;
        shadow_d   = shadow_q;
        rst_d      = rst_q;
        enbTx_d    = enbTx_q;
        enbRx_d    = enbRx_q;
        phaseSel_d = phaseSel_q;
        runLog_d   = 1'b0;
        readLog_d  = readLog_q;
        addrLog_d  = addrLog_q;
`ifdef GPIO_CMD_BER_SNAPSHOT_EN
        snapSI_d   = snapSI_q;
        snapSQ_d   = snapSQ_q;
        snapEI_d   = snapEI_q;
        snapEQ_d   = snapEQ_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (cmdEdge) begin
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                state_d = ST_WAIT_REL;
                cnt_d   = '0;
                case (cmdCode)
                    CMD_RESET: begin
                        rst_d      = 1'b1;
                        enbTx_d    = 1'b0;
                        enbRx_d    = 1'b0;
                        phaseSel_d = 2'b00;
                        readLog_d  = 1'b0;
                        state_d    = ST_RST_HOLD;
                    end
                    CMD_ENB_TX:   enbTx_d    = argField[0];
                    CMD_ENB_RX:   enbRx_d    = argField[0];
                    CMD_PHASE:    phaseSel_d = argField[1:0];
                    CMD_RUN_MEM:  runLog_d   = 1'b1;
                    CMD_READ_MEM: readLog_d  = argField[0];
                    CMD_ADDR_MEM: begin
                        addrLog_d = argField[BRAM_ADDR_WIDTH-1:0];
                        state_d   = ST_MEM_WAIT;
                    end
                    CMD_BER_S_I, CMD_BER_S_Q, CMD_BER_E_I, CMD_BER_E_Q: begin
                        gpi_d    = 32'(berSel);
                        shadow_d = 32'(berSel >> 32);
`ifdef GPIO_CMD_BER_SNAPSHOT_EN
                        if (cmdCode == CMD_BER_S_I) begin
                            snapSI_d = i_ber_samp_i;
                            snapSQ_d = i_ber_samp_q;
                            snapEI_d = i_ber_err_i;
                            snapEQ_d = i_ber_err_q;
                        end
`endif
                    end
                    CMD_BER_H:    gpi_d = shadow_q;
                    CMD_MEM_FULL: gpi_d = {31'b0, i_mem_full};
                    default: ;
                endcase
            end

            ST_MEM_WAIT: begin
                if (cnt_q == MEM_LAST) begin
                    gpi_d   = 32'(i_log_data);
                    state_d = ST_WAIT_REL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_RST_HOLD: begin
                if (cnt_q == RST_LAST) begin
                    rst_d   = 1'b0;
                    state_d = ST_WAIT_REL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_WAIT_REL: begin
                if (!enbSync) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            settle_q   <= '0;
            armed_q    <= 1'b0;
            enbPrev_q  <= 1'b0;
            gpi_q      <= '0;
            shadow_q   <= '0;
            rst_q      <= 1'b0;
            enbTx_q    <= 1'b0;
            enbRx_q    <= 1'b0;
            phaseSel_q <= 2'b00;
            runLog_q   <= 1'b0;
            readLog_q  <= 1'b0;
            addrLog_q  <= '0;
`ifdef GPIO_CMD_BER_SNAPSHOT_EN
            snapSI_q   <= '0;
            snapSQ_q   <= '0;
            snapEI_q   <= '0;
            snapEQ_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            settle_q   <= settle_d;
            armed_q    <= armed_d;
            enbPrev_q  <= enbPrev_d;
            gpi_q      <= gpi_d;
            shadow_q   <= shadow_d;
            rst_q      <= rst_d;
            enbTx_q    <= enbTx_d;
            enbRx_q    <= enbRx_d;
            phaseSel_q <= phaseSel_d;
            runLog_q   <= runLog_d;
            readLog_q  <= readLog_d;
            addrLog_q  <= addrLog_d;
`ifdef GPIO_CMD_BER_SNAPSHOT_EN
            snapSI_q   <= snapSI_d;
            snapSQ_q   <= snapSQ_d;
            snapEI_q   <= snapEI_d;
            snapEQ_q   <= snapEQ_d;
`endif
        end
    end

    assign o_gpi       = gpi_q;
    assign o_rst       = rst_q;
    assign o_enb_tx    = enbTx_q;
    assign o_enb_rx    = enbRx_q;
    assign o_phase_sel = phaseSel_q;
    assign o_run_log   = runLog_q;
    assign o_read_log  = readLog_q;
    assign o_addr_log  = addrLog_q;

endmodule

// File: tb/tb_gpio_cmd_ctrl.sv
// Directed self-checking bench for gpio_cmd_ctrl: vector table plus multi-cycle corner sequences.
module tb_gpio_cmd_ctrl;

    logic        clk = 1'b0;
    logic        i_resetn;
    logic [31:0] i_gpo;
    logic [31:0] o_gpi;
    logic        o_rst, o_enb_tx, o_enb_rx, o_run_log, o_read_log;
    logic [1:0]  o_phase_sel;
    logic [14:0] o_addr_log;
    logic [15:0] i_log_data;
    logic        i_mem_full;
    logic [63:0] i_ber_samp_i, i_ber_samp_q, i_ber_err_i, i_ber_err_q;

    gpio_cmd_ctrl #(
        .BRAM_ADDR_WIDTH (15),
        .BRAM_DATA_WIDTH (16),
        .NB_BER          (64),
        .RST_PULSE_CYC   (16)
    ) dut (
        .clk          (clk),
        .i_resetn     (i_resetn),
        .i_gpo        (i_gpo),
        .o_gpi        (o_gpi),
        .o_rst        (o_rst),
        .o_enb_tx     (o_enb_tx),
        .o_enb_rx     (o_enb_rx),
        .o_phase_sel  (o_phase_sel),
        .o_run_log    (o_run_log),
        .o_read_log   (o_read_log),
        .o_addr_log   (o_addr_log),
        .i_log_data   (i_log_data),
        .i_mem_full   (i_mem_full),
        .i_ber_samp_i (i_ber_samp_i),
        .i_ber_samp_q (i_ber_samp_q),
        .i_ber_err_i  (i_ber_err_i),
        .i_ber_err_q  (i_ber_err_q)
    );

    always #5 clk = ~clk;

    int testsRun    = 0;
    int testsFailed = 0;
    int runPulses   = 0;
    int rstCycles   = 0;

    // Count pulse widths on the falling edge, away from the DUT update edge.
    always @(negedge clk) begin
        if (o_run_log) runPulses++;
        if (o_rst)     rstCycles++;
    end

    typedef struct {
        logic [7:0]  code;
        logic [22:0] arg;
        logic [15:0] logData;
        logic        memFull;
        logic        memWait;
        logic [31:0] gpi;
        logic        tx;
        logic        rx;
        logic [1:0]  phase;
        logic        readLog;
        logic        runLog;
        logic        rst;
        logic [14:0] addr;
    } vec_t;

    vec_t vecs[19];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Raises the strobe with the given command and returns just after the edge that leaves EXEC.
    task automatic applyStimulus(input logic [7:0] code, input logic [22:0] arg);
        @(negedge clk);
        i_gpo = {code, 1'b1, arg};
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic releaseCmd();
        @(negedge clk);
        i_gpo[23] = 1'b0;
        repeat (25) @(negedge clk);
    endtask

    initial begin
        //            code   arg         logData  mf    mw    gpi           tx    rx    ph     rl    run   rst   addr
        vecs[0]  = '{8'd1,   23'd1,      16'h0,   1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 15'h0};
        vecs[1]  = '{8'd2,   23'd1,      16'h0,   1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 15'h0};
        vecs[2]  = '{8'd3,   23'd7,      16'h0,   1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 15'h0};
        vecs[3]  = '{8'd5,   23'd1,      16'h0,   1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 15'h0};
        vecs[4]  = '{8'd12,  23'd0,      16'h0,   1'b1, 1'b0, 32'h1,        1'b1, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 15'h0};
        vecs[5]  = '{8'd13,  23'h7FFFFF, 16'h0,   1'b1, 1'b0, 32'h1,        1'b1, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 15'h0};
        vecs[6]  = '{8'd8,   23'd0,      16'h0,   1'b0, 1'b0, 32'hCCCCDDDD, 1'b1, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 15'h0};
        vecs[7]  = '{8'd11,  23'd0,      16'h0,   1'b0, 1'b0, 32'hAAAABBBB, 1'b1, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 15'h0};
        vecs[8]  = '{8'd9,   23'd0,      16'h0,   1'b0, 1'b0, 32'h9ABCDEF0, 1'b1, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 15'h0};
        vecs[9]  = '{8'd10,  23'd0,      16'h0,   1'b0, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 15'h0};
        vecs[10] = '{8'd11,  23'd0,      16'h0,   1'b0, 1'b0, 32'h0BADF00D, 1'b1, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 15'h0};
        vecs[11] = '{8'd4,   23'd0,      16'h0,   1'b0, 1'b0, 32'h0BADF00D, 1'b1, 1'b1, 2'd3, 1'b1, 1'b1, 1'b0, 15'h0};
        vecs[12] = '{8'd0,   23'd0,      16'h0,   1'b0, 1'b0, 32'h0BADF00D, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 15'h0};
        vecs[13] = '{8'd6,   23'h41234,  16'h5A5A,1'b0, 1'b1, 32'h00005A5A, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 15'h1234};
        vecs[14] = '{8'd255, 23'd0,      16'h0,   1'b0, 1'b0, 32'h00005A5A, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 15'h1234};
        vecs[15] = '{8'd1,   23'd1,      16'h0,   1'b0, 1'b0, 32'h00005A5A, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 15'h1234};
        vecs[16] = '{8'd1,   23'h7FFFFE, 16'h0,   1'b0, 1'b0, 32'h00005A5A, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 15'h1234};
        vecs[17] = '{8'd12,  23'd0,      16'h0,   1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 15'h1234};
        vecs[18] = '{8'd3,   23'd1,      16'h0,   1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 15'h1234};

        i_resetn     = 1'b0;
        i_gpo        = '0;
        i_log_data   = '0;
        i_mem_full   = 1'b0;
        i_ber_samp_i = 64'h0000_0005_0000_0123;
        i_ber_samp_q = 64'hAAAA_BBBB_CCCC_DDDD;
        i_ber_err_i  = 64'h1234_5678_9ABC_DEF0;
        i_ber_err_q  = 64'h0BAD_F00D_FFFF_FFFF;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset gpi",      o_gpi, 32'h0);
        checkOutput("reset rst",      32'(o_rst), 32'h0);
        checkOutput("reset enb_tx",   32'(o_enb_tx), 32'h0);
        checkOutput("reset enb_rx",   32'(o_enb_rx), 32'h0);
        checkOutput("reset phase",    32'(o_phase_sel), 32'h0);
        checkOutput("reset run_log",  32'(o_run_log), 32'h0);
        checkOutput("reset read_log", 32'(o_read_log), 32'h0);
        checkOutput("reset addr",     32'(o_addr_log), 32'h0);
        @(negedge clk);
        i_resetn = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 19; i++) begin
            i_log_data = vecs[i].logData;
            i_mem_full = vecs[i].memFull;
            applyStimulus(vecs[i].code, vecs[i].arg);
            if (vecs[i].memWait) begin
                repeat (2) @(posedge clk);
                #1;
            end
            checkOutput($sformatf("vec%0d gpi", i),      o_gpi, vecs[i].gpi);
            checkOutput($sformatf("vec%0d enb_tx", i),   32'(o_enb_tx), 32'(vecs[i].tx));
            checkOutput($sformatf("vec%0d enb_rx", i),   32'(o_enb_rx), 32'(vecs[i].rx));
            checkOutput($sformatf("vec%0d phase", i),    32'(o_phase_sel), 32'(vecs[i].phase));
            checkOutput($sformatf("vec%0d read_log", i), 32'(o_read_log), 32'(vecs[i].readLog));
            checkOutput($sformatf("vec%0d run_log", i),  32'(o_run_log), 32'(vecs[i].runLog));
            checkOutput($sformatf("vec%0d rst", i),      32'(o_rst), 32'(vecs[i].rst));
            checkOutput($sformatf("vec%0d addr", i),     32'(o_addr_log), 32'(vecs[i].addr));
            releaseCmd();
        end

        // Phase command: latency of exactly 4 clocks from the first sample of the strobe.
        @(negedge clk);
        i_gpo = {8'd3, 1'b1, 23'd2};
        repeat (3) @(posedge clk);
        #1;
        checkOutput("seqA phase before", 32'(o_phase_sel), 32'd1);
        @(negedge clk);
        i_gpo[23] = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("seqA phase at 4", 32'(o_phase_sel), 32'd2);
        repeat (25) @(negedge clk);
        checkOutput("seqA phase hold", 32'(o_phase_sel), 32'd2);

        // Soft reset pulse width and enable clearing.
        applyStimulus(8'd1, 23'd1);
        releaseCmd();
        checkOutput("seqB enb_tx set", 32'(o_enb_tx), 32'd1);
        rstCycles = 0;
        applyStimulus(8'd0, 23'd0);
        checkOutput("seqB rst high", 32'(o_rst), 32'd1);
        releaseCmd();
        checkOutput("seqB rst width", 32'(rstCycles), 32'd16);
        checkOutput("seqB enb_tx clr", 32'(o_enb_tx), 32'd0);
        checkOutput("seqB rst low", 32'(o_rst), 32'd0);

        // Split BER read: low word first, then the high word from the shadow.
        applyStimulus(8'd7, 23'd0);
        checkOutput("seqC ber low", o_gpi, 32'h0000_0123);
        releaseCmd();
        applyStimulus(8'd11, 23'd0);
        checkOutput("seqC ber high", o_gpi, 32'h0000_0005);
        releaseCmd();

        // Memory read: address immediately, data two clocks after EXEC.
        i_log_data = 16'hBEEF;
        applyStimulus(8'd6, 23'h2A9C);
        checkOutput("seqD addr", 32'(o_addr_log), 32'h2A9C);
        @(posedge clk);
        #1;
        checkOutput("seqD gpi held", o_gpi, 32'h0000_0005);
        @(posedge clk);
        #1;
        checkOutput("seqD gpi data", o_gpi, 32'h0000_BEEF);
        releaseCmd();

        // Run pulse with a second rise arriving in WAIT_REL, then a long held level.
        runPulses = 0;
        @(negedge clk);
        i_gpo = {8'd4, 1'b1, 23'd0};
        @(negedge clk);
        i_gpo[23] = 1'b0;
        @(negedge clk);
        i_gpo[23] = 1'b1;
        repeat (30) @(negedge clk);
        i_gpo[23] = 1'b0;
        repeat (25) @(negedge clk);
        checkOutput("seqE run pulses", 32'(runPulses), 32'd1);

        // Hard reset in the middle of RST_HOLD, strobe still high across release.
        applyStimulus(8'd0, 23'd0);
        checkOutput("seqF rst high", 32'(o_rst), 32'd1);
        repeat (4) @(posedge clk);
        #3;
        i_resetn = 1'b0;
        #1;
        checkOutput("seqF rst async", 32'(o_rst), 32'd0);
        checkOutput("seqF gpi async", o_gpi, 32'h0);
        checkOutput("seqF addr async", 32'(o_addr_log), 32'h0);
        repeat (2) @(negedge clk);
        rstCycles = 0;
        runPulses = 0;
        i_resetn  = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("seqF no retrigger", 32'(rstCycles), 32'd0);
        checkOutput("seqF rst low", 32'(o_rst), 32'd0);
        i_gpo = '0;
        repeat (5) @(negedge clk);
        applyStimulus(8'd2, 23'd1);
        checkOutput("seqF idle after", 32'(o_enb_rx), 32'd1);
        releaseCmd();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
